// File: rtl/s_machine_pkg.sv
// s_machine_pkg: shared defaults, opcode constants and FSM state encoding for the instruction sequencer.
package s_machine_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DONE_TIMEOUT_DEF = 15;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts execute cycles after a clear and flags expiry so that the
// owner leaves EXEC exactly TIMEOUT cycles after the start pulse.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  // Cleared during the start cycle; the last execute cycle is the one before start+TIMEOUT.
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 2);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    expired = enable && (cnt_q == LAST);
    cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: fetches instructions over a shared memory port and hands them to an interpreter.
// Optional INST_SEQ_BREAKPOINT_EN adds bp_addr/bp_en, parking in IDLE while pc matches.
module inst_sequencer
  import s_machine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef INST_SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic              start,
  input  logic              done,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic              ex_we,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic exec, go, wd_clear, wd_expired;
`ifdef INST_SEQ_BREAKPOINT_EN
  assign go = run && !(bp_en && pc_q == bp_addr);
`else
  assign go = run;
`endif
  seq_watchdog #(.TIMEOUT(DONE_TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (exec),
    .expired(wd_expired)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    wd_clear = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = go ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        inst_d = mem_rdata;
        state_d = (mem_rdata[DATA_W-1 -: 4] == OP_HALT) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        wd_clear = 1'b1;
        state_d = S_EXEC;
      end
      // done takes priority over a simultaneous watchdog expiry
      S_EXEC: begin
        pc_d = done ? pc_q + 1'b1 : pc_q;
        state_d = done ? S_IDLE : wd_expired ? S_FAULT : S_EXEC;
      end
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    exec = state_q == S_EXEC;
    mem_addr = exec ? ex_addr : pc_q;
    mem_we = exec && ex_we;
    mem_wdata = exec ? ex_wdata : '0;
    start = state_q == S_ISSUE;
    halted = state_q == S_HALT;
    fault = state_q == S_FAULT;
    pc = pc_q;
    inst = inst_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      inst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
  end
endmodule
